// File: rtl/shift_sub_pkg.sv
// -----------------------------------------------------------------------------
// shift_sub_pkg
// Shared definitions for the sequential restoring divider:
//   - DEFAULT_WIDTH : default operand width
//   - state_e       : controller state encoding (2'b11 is unused/illegal)
// -----------------------------------------------------------------------------
package shift_sub_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/shift_sub_divider_step.sv
// -----------------------------------------------------------------------------
// divider_step
// One combinational restoring-division step.
// Shifts {R,Q} left by one, trial-subtracts D from the shifted remainder and
// either commits the difference (quotient bit 1) or restores R (quotient bit 0).
// Ports:
//   r_i  [WIDTH-1:0]  current partial remainder
//   q_i  [WIDTH-1:0]  current dividend/quotient shift register
//   d_i  [WIDTH-1:0]  divisor
//   r_o  [WIDTH-1:0]  partial remainder after this step
//   q_o  [WIDTH-1:0]  quotient register after this step
// -----------------------------------------------------------------------------
module divider_step
  import shift_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] r_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] r_o,
  output logic [WIDTH-1:0] q_o
);

  logic [2*WIDTH-1:0] rq_shift_s;
  logic [WIDTH-1:0]   r_shift_s;
  logic [WIDTH-1:0]   q_shift_s;
  logic [WIDTH:0]     trial_s;

  // The MSB of R shifted out here is always zero: after k steps R < 2^k,
  // so the shifted remainder never exceeds WIDTH bits.
  assign rq_shift_s = {r_i, q_i} << 1'b1;
  assign r_shift_s  = rq_shift_s[2*WIDTH-1:WIDTH];
  assign q_shift_s  = rq_shift_s[WIDTH-1:0];

  // Extra top bit acts as the borrow: set when D does not fit.
  assign trial_s = {1'b0, r_shift_s} - {1'b0, d_i};

  // Commit or restore the remainder and insert the new quotient bit.
  always_comb begin
    r_o = r_shift_s;
    q_o = q_shift_s;
    if (trial_s[WIDTH] == 1'b0) begin
      r_o = trial_s[WIDTH-1:0];
      q_o = q_shift_s | {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      r_o = r_shift_s;
      q_o = q_shift_s;
    end
  end

endmodule

// File: rtl/shift_sub_divider.sv
// -----------------------------------------------------------------------------
// shift_sub_divider
// Sequential unsigned restoring divider, one quotient bit per clock.
// start/done handshake matches the shift-add multiplier.
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   start_i        request, sampled only in IDLE
//   dividend_i     numerator, captured on an accepted start
//   divisor_i      denominator, captured on an accepted start
//   quotient_o     registered quotient of the last completed operation
//   remainder_o    registered remainder of the last completed operation
//   busy_o         high while iterating
//   done_o         one-cycle completion pulse
//   div_by_zero_o  set when the last completed operation had divisor 0
// A zero divisor skips iteration and goes straight to DONE on the accepting
// edge, reporting quotient all-ones and remainder = dividend.
// -----------------------------------------------------------------------------
module shift_sub_divider
  import shift_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_by_zero_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] step_r_s;
  logic [WIDTH-1:0] step_q_s;

  divider_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .r_i (r_q),
    .q_i (q_q),
    .d_i (d_q),
    .r_o (step_r_s),
    .q_o (step_q_s)
  );

  // Next-state, datapath and output-register logic for the controller.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;
    busy_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          q_d   = dividend_i;
          d_d   = divisor_i;
          r_d   = {WIDTH{1'b0}};
          cnt_d = {CNT_W{1'b0}};
          if (divisor_i == {WIDTH{1'b0}}) begin
            // Fast path: the restoring result for D=0 is known up front.
            state_d = DONE;
            quo_d   = {WIDTH{1'b1}};
            rem_d   = dividend_i;
            dbz_d   = 1'b1;
            done_d  = 1'b1;
          end else begin
            state_d = CALC;
            busy_d  = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end

      CALC: begin
        r_d   = step_r_s;
        q_d   = step_q_s;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          // Final bit: publish the step output directly on the same edge.
          state_d = DONE;
          quo_d   = step_q_s;
          rem_d   = step_r_s;
          dbz_d   = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = CALC;
          busy_d  = 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      r_q     <= {WIDTH{1'b0}};
      q_q     <= {WIDTH{1'b0}};
      d_q     <= {WIDTH{1'b0}};
      quo_q   <= {WIDTH{1'b0}};
      rem_q   <= {WIDTH{1'b0}};
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign quotient_o    = quo_q;
  assign remainder_o   = rem_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_shift_sub_divider.sv
// -----------------------------------------------------------------------------
// tb_shift_sub_divider
// Directed and sweep bench for shift_sub_divider at WIDTH=4 and WIDTH=8.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_shift_sub_divider;

  logic       clk = 1'b0;
  logic       rst;
  logic       start4, start8;
  logic [3:0] dvd4, dvs4, quo4, rem4;
  logic [7:0] dvd8, dvs8, quo8, rem8;
  logic       busy4, done4, dbz4;
  logic       busy8, done8, dbz8;

  int checks   = 0;
  int failures = 0;
  int overlap  = 0;

  always #5 clk = ~clk;

  shift_sub_divider #(.WIDTH(4)) dut4 (
    .clk (clk), .rst (rst), .start_i (start4),
    .dividend_i (dvd4), .divisor_i (dvs4),
    .quotient_o (quo4), .remainder_o (rem4),
    .busy_o (busy4), .done_o (done4), .div_by_zero_o (dbz4)
  );

  shift_sub_divider #(.WIDTH(8)) dut8 (
    .clk (clk), .rst (rst), .start_i (start8),
    .dividend_i (dvd8), .divisor_i (dvs8),
    .quotient_o (quo8), .remainder_o (rem8),
    .busy_o (busy8), .done_o (done8), .div_by_zero_o (dbz8)
  );

  // busy and done must never be high together on either instance.
  always @(negedge clk) begin
    if ((busy4 && done4) || (busy8 && done8)) overlap++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Run one operation; returns outputs, edges from accept to done, busy cycles.
  task automatic op(input bit w8, input logic [7:0] a, input logic [7:0] b,
                    output logic [7:0] q, output logic [7:0] r, output logic dbz,
                    output int lat, output int bc);
    @(negedge clk);
    if (w8) begin dvd8 = a; dvs8 = b; start8 = 1'b1; end
    else begin dvd4 = a[3:0]; dvs4 = b[3:0]; start4 = 1'b1; end
    @(negedge clk);
    start4 = 1'b0; start8 = 1'b0;
    lat = 0; bc = 0;
    while (!(w8 ? done8 : done4) && lat < 40) begin
      if (w8 ? busy8 : busy4) bc++;
      @(negedge clk);
      lat++;
    end
    chk("op_timeout", (lat < 40) ? 32'd1 : 32'd0, 32'd1);
    q   = w8 ? quo8 : {4'b0000, quo4};
    r   = w8 ? rem8 : {4'b0000, rem4};
    dbz = w8 ? dbz8 : dbz4;
    @(negedge clk);
    chk("done_pulse_width", {31'd0, (w8 ? done8 : done4)}, 32'd0);
  endtask

  initial begin
    logic [7:0] q, r;
    logic       dbz;
    int         lat, bc, first, second, cnt_done;
    int         ea, eb;

    rst = 1'b1; start4 = 1'b0; start8 = 1'b0;
    dvd4 = 4'd0; dvs4 = 4'd0; dvd8 = 8'd0; dvs8 = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_quotient",  {28'd0, quo4}, 32'd0);
    chk("rst_remainder", {28'd0, rem4}, 32'd0);
    chk("rst_busy",      {31'd0, busy4}, 32'd0);
    chk("rst_done",      {31'd0, done4}, 32'd0);
    chk("rst_dbz",       {31'd0, dbz4}, 32'd0);
    rst = 1'b0;

    // 13 / 3 = 4 r 1, 4 edges, busy for exactly 4 cycles
    op(1'b0, 8'd13, 8'd3, q, r, dbz, lat, bc);
    chk("13div3_q", q, 32'd4);
    chk("13div3_r", r, 32'd1);
    chk("13div3_dbz", dbz, 32'd0);
    chk("13div3_lat", lat, 32'd4);
    chk("13div3_busy", bc, 32'd4);

    op(1'b0, 8'd15, 8'd1, q, r, dbz, lat, bc);
    chk("15div1_q", q, 32'd15);
    chk("15div1_r", r, 32'd0);
    op(1'b0, 8'd5, 8'd7, q, r, dbz, lat, bc);
    chk("5div7_q", q, 32'd0);
    chk("5div7_r", r, 32'd5);
    op(1'b0, 8'd0, 8'd5, q, r, dbz, lat, bc);
    chk("0div5_q", q, 32'd0);
    chk("0div5_r", r, 32'd0);

    // Divide by zero: DONE entered on the accepting edge, busy never set
    op(1'b0, 8'd9, 8'd0, q, r, dbz, lat, bc);
    chk("9div0_q", q, 32'd15);
    chk("9div0_r", r, 32'd9);
    chk("9div0_dbz", dbz, 32'd1);
    chk("9div0_lat", lat, 32'd0);
    chk("9div0_busy", bc, 32'd0);
    op(1'b0, 8'd8, 8'd2, q, r, dbz, lat, bc);
    chk("8div2_q", q, 32'd4);
    chk("8div2_r", r, 32'd0);
    chk("8div2_dbz", dbz, 32'd0);

    // Start pulses during CALC and DONE are ignored
    @(negedge clk); dvd4 = 4'd13; dvs4 = 4'd3; start4 = 1'b1;
    @(negedge clk); dvd4 = 4'd2; dvs4 = 4'd1;        // after t0: CALC
    @(negedge clk); start4 = 1'b0;                   // after t0+1
    @(negedge clk);                                  // after t0+2
    @(negedge clk); dvd4 = 4'd7; dvs4 = 4'd7; start4 = 1'b1; // after t0+3
    @(negedge clk);                                  // after t0+4: DONE
    chk("ign_done", {31'd0, done4}, 32'd1);
    chk("ign_q", {28'd0, quo4}, 32'd4);
    chk("ign_r", {28'd0, rem4}, 32'd1);
    @(negedge clk); start4 = 1'b0;                   // after t0+5: IDLE
    chk("ign_idle_busy", {31'd0, busy4}, 32'd0);
    @(negedge clk);                                  // after t0+6
    chk("ign_no_accept", {31'd0, busy4 | done4}, 32'd0);
    chk("ign_q_hold", {28'd0, quo4}, 32'd4);

    // Start held high: back-to-back results 6 cycles apart
    @(negedge clk); dvd4 = 4'd13; dvs4 = 4'd3; start4 = 1'b1;
    first = -1; second = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done4) begin
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
    end
    start4 = 1'b0;
    chk("held_seen", (second >= 0) ? 32'd1 : 32'd0, 32'd1);
    chk("held_gap", second - first, 32'd6);
    chk("held_q", {28'd0, quo4}, 32'd4);
    for (int i = 0; i < 20 && (busy4 || done4); i++) @(negedge clk);
    @(negedge clk);
    chk("held_drain", {31'd0, busy4 | done4}, 32'd0);

    // Reset in the 2nd CALC cycle aborts without a done pulse
    @(negedge clk); dvd4 = 4'd13; dvs4 = 4'd3; start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;                   // after t0
    @(negedge clk); rst = 1'b1;                      // after t0+1
    @(negedge clk);                                  // after t0+2 (reset edge)
    chk("abort_q", {28'd0, quo4}, 32'd0);
    chk("abort_r", {28'd0, rem4}, 32'd0);
    chk("abort_busy", {31'd0, busy4}, 32'd0);
    chk("abort_done", {31'd0, done4}, 32'd0);
    chk("abort_dbz", {31'd0, dbz4}, 32'd0);
    rst = 1'b0;
    cnt_done = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done4 || busy4) cnt_done++;
    end
    chk("abort_no_done", cnt_done, 32'd0);
    op(1'b0, 8'd14, 8'd4, q, r, dbz, lat, bc);
    chk("14div4_q", q, 32'd3);
    chk("14div4_r", r, 32'd2);

    // WIDTH=8 directed
    op(1'b1, 8'd255, 8'd16, q, r, dbz, lat, bc);
    chk("255div16_q", q, 32'd15);
    chk("255div16_r", r, 32'd15);
    chk("255div16_lat", lat, 32'd8);
    chk("255div16_busy", bc, 32'd8);

    // Exhaustive WIDTH=4 against a/b, a%b
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        op(1'b0, 8'(a), 8'(b), q, r, dbz, lat, bc);
        ea = (b == 0) ? 15 : a / b;
        eb = (b == 0) ? a : a % b;
        chk($sformatf("sw4_q %0d/%0d", a, b), q, ea);
        chk($sformatf("sw4_r %0d/%0d", a, b), r, eb);
        chk($sformatf("sw4_dbz %0d/%0d", a, b), dbz, (b == 0) ? 32'd1 : 32'd0);
        chk($sformatf("sw4_lat %0d/%0d", a, b), lat, (b == 0) ? 32'd0 : 32'd4);
      end
    end

    // Random WIDTH=8
    for (int n = 0; n < 1000; n++) begin
      int a, b;
      a = int'($urandom_range(255, 0));
      b = int'($urandom_range(255, 0));
      if (n < 8) b = 0;
      op(1'b1, 8'(a), 8'(b), q, r, dbz, lat, bc);
      ea = (b == 0) ? 255 : a / b;
      eb = (b == 0) ? a : a % b;
      chk($sformatf("sw8_q %0d/%0d", a, b), q, ea);
      chk($sformatf("sw8_r %0d/%0d", a, b), r, eb);
      chk($sformatf("sw8_dbz %0d/%0d", a, b), dbz, (b == 0) ? 32'd1 : 32'd0);
      chk($sformatf("sw8_lat %0d/%0d", a, b), lat, (b == 0) ? 32'd0 : 32'd8);
    end

    chk("busy_done_overlap", overlap, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
